// File: rtl/ysyx_22041207_ifu_pkg.sv
// Shared types and constants for the prefetching instruction-fetch unit.
package ysyx_22041207_ifu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } ifu_state_e;

  localparam logic [7:0]  AR_SIZE_WORD     = 8'b0000_1111;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ysyx_22041207_ifu_fifo.sv
// Prefetch queue: power-of-two FIFO of {pc, inst} entries with synchronous flush.
module ysyx_22041207_ifu_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_en, pop_en;

  // Flush dominates both push and pop so a redirect always leaves the queue empty.
  always_comb begin
    push_en  = push && !flush;
    pop_en   = pop && (count_q != '0) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push_en);
      rd_ptr_d = rd_ptr_q + AW'(pop_en);
      count_d  = count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) mem_q[wr_ptr_q] <= push_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ysyx_22041207_ifu_prefetch.sv
// Instruction-fetch unit: one outstanding sequential read, DEPTH-entry prefetch queue toward ID.
module ysyx_22041207_ifu_prefetch
  import ysyx_22041207_ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            ar_valid,
  input  logic            ar_ready,
  output logic [XLEN-1:0] ar_addr,
  output logic [7:0]      ar_size,
  input  logic            r_valid,
  output logic            r_ready,
  input  logic [63:0]     r_data
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            squash_q, squash_d;

  logic [CW-1:0]   count;
  logic [CW-1:0]   eff_count;
  logic [CW:0]     occupancy;
  logic            in_flight, can_issue;
  logic            push, pop;
  logic [31:0]     inst_sel;
  logic [XLEN+31:0] head;

  // A redirect empties the queue this cycle, so issue decisions see it as empty.
  assign in_flight = (state_q != S_IDLE);
  assign eff_count = redirect_valid ? '0 : count;
  assign occupancy = {1'b0, eff_count} + {{CW{1'b0}}, in_flight};
  assign can_issue = occupancy < (CW+1)'(DEPTH);

  assign inst_sel = req_pc_q[2] ? r_data[63:32] : r_data[31:0];
  assign push     = (state_q == S_DATA) && r_valid && !squash_q && !redirect_valid;
  assign pop      = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    squash_d   = squash_q;
    if (redirect_valid) fetch_pc_d = redirect_pc & ~XLEN'(3);
    case (state_q)
      S_IDLE: begin
        if (can_issue) begin
          state_d  = S_ADDR;
          req_pc_d = fetch_pc_d;
        end
      end
      S_ADDR: begin
        // The address phase cannot be withdrawn; a redirect only marks its data as dead.
        if (redirect_valid) squash_d = 1'b1;
        if (ar_ready) begin
          state_d = S_DATA;
          if (!redirect_valid && !squash_q) fetch_pc_d = req_pc_q + XLEN'(4);
        end
      end
      S_DATA: begin
        if (redirect_valid) squash_d = 1'b1;
        if (r_valid) begin
          squash_d = 1'b0;
          if (can_issue) begin
            state_d  = S_ADDR;
            req_pc_d = fetch_pc_d;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      squash_q   <= squash_d;
    end
  end

  ysyx_22041207_ifu_fifo #(
    .W     (XLEN + 32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({req_pc_q, inst_sel}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign out_valid = (count != '0);
  assign out_pc    = head[XLEN+31:32];
  assign out_inst  = head[31:0];
  assign ar_valid  = (state_q == S_ADDR);
  assign ar_addr   = req_pc_q;
  assign ar_size   = AR_SIZE_WORD;
  assign r_ready   = (state_q == S_DATA);

endmodule

// File: tb/tb_ysyx_22041207_ifu_prefetch.sv
// Directed bench: memory responder, transaction-level fetch/queue model and per-cycle compare.
module tb_ysyx_22041207_ifu_prefetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        ar_valid, ar_ready;
  logic [63:0] ar_addr;
  logic [7:0]  ar_size;
  logic        r_valid, r_ready;
  logic [63:0] r_data;

  ysyx_22041207_ifu_prefetch #(.XLEN(64), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_size(ar_size),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Memory image: every word's instruction is a fixed function of its address.
  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'hFFFF_0000;
  endfunction

  function automatic logic [63:0] mem64(input logic [63:0] a);
    return {inst_of({a[63:3], 3'b100}), inst_of({a[63:3], 3'b000})};
  endfunction

  // ---------------- model ----------------
  typedef struct { logic [63:0] pc; logic sq; } req_t;
  req_t        outst[$];
  logic [63:0] expq[$];
  logic [63:0] exp_ar;
  logic        held_flag;
  logic [63:0] held_addr;
  logic        prev_wait;
  logic [63:0] prev_addr;
  logic [63:0] ar_hist[$];
  logic [63:0] out_hist_pc[$];
  logic [31:0] out_hist_inst[$];

  logic        ev_ar, ev_r;
  logic [63:0] ev_ar_addr;
  logic        m_ho, m_hr, m_ha, m_rd;
  req_t        m_req;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      outst.delete();
      expq.delete();
      exp_ar    = 64'h8000_0000;
      held_flag = 1'b0;
      prev_wait = 1'b0;
      ev_ar     = 1'b0;
      ev_r      = 1'b0;
    end else begin
      chk("ar_size", {56'd0, ar_size}, 64'h0F);
      chk("out_valid", {63'd0, out_valid}, {63'd0, expq.size() != 0});
      if (out_valid && expq.size() != 0) begin
        chk("out_pc", out_pc, expq[0]);
        chk("out_inst", {32'd0, out_inst}, {32'd0, inst_of(expq[0])});
      end
      if (prev_wait) begin
        chk("ar_hold_valid", {63'd0, ar_valid}, 64'd1);
        chk("ar_hold_addr", ar_addr, prev_addr);
      end
      if (r_ready && outst.size() == 0) timeout_fail("r_ready_without_request");

      m_ho = out_valid && out_ready;
      m_hr = r_valid && r_ready;
      m_ha = ar_valid && ar_ready;
      m_rd = redirect_valid;

      if (m_ho) begin
        out_hist_pc.push_back(out_pc);
        out_hist_inst.push_back(out_inst);
        if (!m_rd && expq.size() != 0) void'(expq.pop_front());
      end
      if (m_hr) begin
        if (outst.size() == 0) timeout_fail("r_handshake_unexpected");
        else begin
          m_req = outst.pop_front();
          if (!m_req.sq && !m_rd) expq.push_back(m_req.pc);
        end
      end
      if (m_ha) begin
        ar_hist.push_back(ar_addr);
        chk("one_outstanding", outst.size(), 64'd0);
        if (held_flag) begin
          chk("ar_addr_held", ar_addr, held_addr);
          m_req.pc = ar_addr; m_req.sq = 1'b1;
          held_flag = 1'b0;
        end else begin
          chk("ar_addr_seq", ar_addr, exp_ar);
          m_req.pc = ar_addr; m_req.sq = m_rd;
          exp_ar = exp_ar + 64'd4;
        end
        outst.push_back(m_req);
      end
      if (m_rd) begin
        expq.delete();
        foreach (outst[i]) outst[i].sq = 1'b1;
        exp_ar = redirect_pc & ~64'd3;
        if (ar_valid && !ar_ready) begin
          held_flag = 1'b1;
          held_addr = ar_addr;
        end
      end
      if (expq.size() > DEPTH) timeout_fail("queue_over_depth");

      prev_wait  = ar_valid && !ar_ready;
      prev_addr  = ar_addr;
      ev_ar      = m_ha;
      ev_ar_addr = ar_addr;
      ev_r       = m_hr;
    end
  end

  // ---------------- memory responder / driver ----------------
  int          lat;
  logic        rsp_busy;
  logic [63:0] rsp_addr;
  int          rsp_wait;

  task automatic tick();
    @(negedge clk);
    if (ev_r) begin
      r_valid  = 1'b0;
      rsp_busy = 1'b0;
    end
    if (ev_ar) begin
      rsp_busy = 1'b1;
      rsp_addr = ev_ar_addr;
      rsp_wait = lat;
    end
    if (rsp_busy && !r_valid) begin
      if (rsp_wait == 0) begin
        r_valid = 1'b1;
        r_data  = mem64(rsp_addr);
      end else begin
        rsp_wait--;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_out_valid(input string nm, input int max);
    for (int i = 0; i < max && !out_valid; i++) tick();
    if (!out_valid) timeout_fail(nm);
  endtask

  task automatic wait_r_ready(input string nm, input int max);
    for (int i = 0; i < max && !r_ready; i++) tick();
    if (!r_ready) timeout_fail(nm);
  endtask

  task automatic wait_ar_valid(input string nm, input int max);
    for (int i = 0; i < max && !ar_valid; i++) tick();
    if (!ar_valid) timeout_fail(nm);
  endtask

  task automatic reset_responder();
    r_valid  = 1'b0;
    r_data   = '0;
    rsp_busy = 1'b0;
    rsp_wait = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    out_ready = 1'b1; ar_ready = 1'b1; lat = 0;
    reset_responder();
    ticks(3);
    chk("rst_ar_valid", {63'd0, ar_valid}, 64'd0);
    chk("rst_r_ready", {63'd0, r_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_inst", {32'd0, out_inst}, 64'd0);

    // 1: sequential fetch from RESET_PC, one-cycle memory
    rst_n = 1'b1;
    chk("ar_valid_before_edge1", {63'd0, ar_valid}, 64'd0);
    tick();
    chk("ar_valid_after_edge1", {63'd0, ar_valid}, 64'd1);
    chk("first_ar_addr", ar_addr, 64'h8000_0000);
    ticks(12);
    if (ar_hist.size() < 3 || out_hist_pc.size() < 3) timeout_fail("seq_progress");
    else begin
      chk("ar0", ar_hist[0], 64'h8000_0000);
      chk("ar1", ar_hist[1], 64'h8000_0004);
      chk("ar2", ar_hist[2], 64'h8000_0008);
      chk("out0_pc", out_hist_pc[0], 64'h8000_0000);
      chk("out0_inst", {32'd0, out_hist_inst[0]}, 64'h7FFF_0000);
      chk("out1_inst_upper", {32'd0, out_hist_inst[1]}, 64'h7FFF_0004);
      chk("out2_inst", {32'd0, out_hist_inst[2]}, 64'h7FFF_0008);
    end

    // 2: ID stalls; queue fills to DEPTH, fetch stops, then drains in order
    out_ready = 1'b0;
    ticks(20);
    chk("full_count", expq.size(), DEPTH);
    chk("full_ar_idle", {63'd0, ar_valid}, 64'd0);
    chk("full_out_valid", {63'd0, out_valid}, 64'd1);
    out_hist_pc.delete();
    out_ready = 1'b1;
    ticks(10);
    if (out_hist_pc.size() < 5) timeout_fail("drain_progress");
    else for (int i = 0; i < 4; i++)
      chk("drain_order", out_hist_pc[i+1] - out_hist_pc[i], 64'd4);

    // 3: redirect while waiting for a slow response
    lat = 3;
    wait_r_ready("wait_data_state", 20);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    lat = 0;
    wait_out_valid("redir_data_out", 40);
    chk("redir_data_pc", out_pc, 64'h8000_0100);
    chk("redir_data_inst", {32'd0, out_inst}, 64'h7FFF_0100);

    // 4: redirect while an address is held by a stalled AR channel
    ar_ready = 1'b0;
    wait_ar_valid("wait_ar_valid", 20);
    ar_hist.delete();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0202;
    tick();
    redirect_valid = 1'b0;
    ticks(3);
    chk("held_ar_valid", {63'd0, ar_valid}, 64'd1);
    ar_ready = 1'b1;
    wait_out_valid("redir_addr_out", 40);
    chk("redir_addr_pc", out_pc, 64'h8000_0200);
    if (ar_hist.size() < 2) timeout_fail("redir_addr_hist");
    else chk("redir_addr_next_ar", ar_hist[1], 64'h8000_0200);

    // 5: redirect coincident with out and r handshakes
    out_ready = 1'b0; lat = 2;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      tick();
      hit = r_valid && r_ready && out_valid;
    end
    if (!hit) timeout_fail("coincide_setup");
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0300; out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; lat = 0;
    chk("coincide_empty", {63'd0, out_valid}, 64'd0);
    wait_out_valid("coincide_out", 40);
    chk("coincide_pc", out_pc, 64'h8000_0300);

    // 6: asynchronous reset in the middle of a read
    lat = 3;
    wait_r_ready("wait_data_reset", 20);
    rst_n = 1'b0;
    #1;
    chk("async_ar_valid", {63'd0, ar_valid}, 64'd0);
    chk("async_r_ready", {63'd0, r_ready}, 64'd0);
    chk("async_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_out_pc", out_pc, 64'd0);
    chk("async_out_inst", {32'd0, out_inst}, 64'd0);
    reset_responder();
    lat = 0;
    tick();
    reset_responder();
    rst_n = 1'b1;
    wait_ar_valid("restart_ar", 5);
    chk("restart_addr", ar_addr, 64'h8000_0000);
    wait_out_valid("restart_out", 20);
    chk("restart_pc", out_pc, 64'h8000_0000);
    ticks(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
